// File: rtl/sccb_txn_arbiter_pkg.sv
// Shared types and defaults for the SCCB transaction arbiter and the
// init sequencer that feeds it.
package sccb_txn_arbiter_pkg;

  localparam int SCCB_FIELD_W       = 16;
  localparam int RDATA_W            = 8;
  localparam int TMO_W              = 10;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_TIMEOUT_PULSES = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Index width for 2..4 requesters.
  function automatic int idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sccb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap.
module sccb_rr_pick
  import sccb_txn_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    int               pos;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_txn_arbiter.sv
// Shares one SCCB transaction controller between NUM_REQ requesters with
// round-robin grant, bounded ack-error retry and a data-pulse timeout.
module sccb_txn_arbiter
  import sccb_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int TIMEOUT_PULSES = DEF_TIMEOUT_PULSES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          rw_i,
  input  logic [SCCB_FIELD_W*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [NUM_REQ-1:0]          err_o,
  output logic [RDATA_W-1:0]          rdata_o,
  output logic                        busy_o,
  input  logic                        data_pulse_i,
  output logic                        sccb_start_o,
  output logic                        sccb_rw_o,
  output logic [SCCB_FIELD_W-1:0]     sccb_data_o,
  input  logic                        sccb_done_i,
  input  logic                        sccb_ack_error_i,
  input  logic [RDATA_W-1:0]          sccb_rdata_i
);

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
  logic                      gnt_rw_q, gnt_rw_d;
  logic [SCCB_FIELD_W-1:0]   gnt_data_q, gnt_data_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [RETRY_W-1:0]        retry_cnt_q, retry_cnt_d;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0]          tmo_inc;
  logic                      start_q, start_d;
  logic                      sccb_rw_q, sccb_rw_d;
  logic [SCCB_FIELD_W-1:0]   sccb_data_q, sccb_data_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d, err_q, err_d;
  logic [RDATA_W-1:0]        rdata_q, rdata_d;
  logic                      busy_q, busy_d;

  logic [NUM_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;

  sccb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign tmo_inc = tmo_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_rw_d    = gnt_rw_q;
    gnt_data_d  = gnt_data_q;
    rr_ptr_d    = rr_ptr_q;
    retry_cnt_d = retry_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    start_d     = start_q;
    sccb_rw_d   = sccb_rw_q;
    sccb_data_d = sccb_data_q;
    ack_d       = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_idx_d   = pick_idx;
          gnt_rw_d    = rw_i[pick_idx];
          gnt_data_d  = wdata_i[pick_idx*SCCB_FIELD_W +: SCCB_FIELD_W];
          rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          retry_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A done still high from the previous op must clear before restarting.
        if (data_pulse_i && !sccb_done_i) begin
          start_d     = 1'b1;
          sccb_rw_d   = gnt_rw_q;
          sccb_data_d = gnt_data_q;
          tmo_cnt_d   = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_pulse_i) begin
          if (sccb_done_i) begin
            start_d = 1'b0;
            if (!sccb_ack_error_i) begin
              if (gnt_rw_q) rdata_d = sccb_rdata_i;
              ack_d[gnt_idx_q] = 1'b1;
              busy_d           = 1'b0;
              state_d          = ST_DONE;
            end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
              retry_cnt_d = retry_cnt_q + 1'b1;
              state_d     = ST_ISSUE;
            end else begin
              err_d[gnt_idx_q] = 1'b1;
              busy_d           = 1'b0;
              state_d          = ST_DONE;
            end
          end else begin
            tmo_cnt_d = tmo_inc;
            if (tmo_inc == TMO_W'(TIMEOUT_PULSES)) begin
              start_d          = 1'b0;
              err_d[gnt_idx_q] = 1'b1;
              busy_d           = 1'b0;
              state_d          = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        // ack/err pulse is visible during this cycle; IDLE may regrant next clk.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      gnt_idx_q   <= '0;
      gnt_rw_q    <= 1'b0;
      gnt_data_q  <= '0;
      rr_ptr_q    <= '0;
      retry_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      start_q     <= 1'b0;
      sccb_rw_q   <= 1'b0;
      sccb_data_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_rw_q    <= gnt_rw_d;
      gnt_data_q  <= gnt_data_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      start_q     <= start_d;
      sccb_rw_q   <= sccb_rw_d;
      sccb_data_q <= sccb_data_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign sccb_start_o = start_q;
  assign sccb_rw_o    = sccb_rw_q;
  assign sccb_data_o  = sccb_data_q;

endmodule

// File: tb/tb_sccb_txn_arbiter.sv
// Scoreboard bench for sccb_txn_arbiter with a behavioural SCCB controller.
module tb_sccb_txn_arbiter;

  localparam int NUM_REQ = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ-1:0]     rw_i;
  logic [16*NUM_REQ-1:0]  wdata_i;
  logic [NUM_REQ-1:0]     ack_o, err_o;
  logic [7:0]             rdata_o;
  logic                   busy_o;
  logic                   data_pulse_i;
  logic                   sccb_start_o, sccb_rw_o;
  logic [15:0]            sccb_data_o;
  logic                   sccb_done_i, sccb_ack_error_i;
  logic [7:0]             sccb_rdata_i;

  always #5 clk_i = ~clk_i;

  sccb_txn_arbiter #(.NUM_REQ(NUM_REQ), .MAX_RETRY(3), .TIMEOUT_PULSES(1023)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .rw_i             (rw_i),
    .wdata_i          (wdata_i),
    .ack_o            (ack_o),
    .err_o            (err_o),
    .rdata_o          (rdata_o),
    .busy_o           (busy_o),
    .data_pulse_i     (data_pulse_i),
    .sccb_start_o     (sccb_start_o),
    .sccb_rw_o        (sccb_rw_o),
    .sccb_data_o      (sccb_data_o),
    .sccb_done_i      (sccb_done_i),
    .sccb_ack_error_i (sccb_ack_error_i),
    .sccb_rdata_i     (sccb_rdata_i)
  );

  typedef struct {
    int          idx;
    bit          is_err;
    bit          rw;
    logic [15:0] data;
    int          starts;
    int          wait_pulses;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          req_cnt[NUM_REQ];
  int          err_left = 0;
  bit          hang = 1'b0;
  logic [7:0]  model_rdata = 8'h00;
  logic [7:0]  exp_rdata = 8'h00;
  int          pulse_div = 0;
  int          lat_cnt = 0;
  bit          start_prev = 1'b0;
  int          starts_seen = 0;
  int          wait_pulses = 0;
  logic [15:0] data_at_start = 16'h0;
  bit          rw_at_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model, requester drivers and output monitor, all on negedge.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      starts_seen      = 0;
      wait_pulses      = 0;
      lat_cnt          = 0;
      sccb_done_i      = 1'b0;
      sccb_ack_error_i = 1'b0;
    end else begin
      if (start_prev && data_pulse_i) wait_pulses++;
      if (sccb_start_o && !start_prev) begin
        starts_seen++;
        data_at_start = sccb_data_o;
        rw_at_start   = sccb_rw_o;
      end
      if (ack_o != '0 || err_o != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({ack_o, err_o}), 32'h0);
        end else begin
          e = sb.pop_front();
          if (!e.is_err && e.rw) exp_rdata = model_rdata;
          chk("ack_vec", 32'(ack_o), e.is_err ? 32'h0 : 32'(1 << e.idx));
          chk("err_vec", 32'(err_o), e.is_err ? 32'(1 << e.idx) : 32'h0);
          chk("busy_at_done", 32'(busy_o), 32'h0);
          chk("start_low_at_done", 32'(sccb_start_o), 32'h0);
          chk("sccb_data", 32'(data_at_start), 32'(e.data));
          chk("sccb_rw", 32'(rw_at_start), 32'(e.rw));
          chk("start_count", 32'(starts_seen), 32'(e.starts));
          chk("rdata", 32'(rdata_o), 32'(exp_rdata));
          if (e.wait_pulses != 0) chk("wait_pulses", 32'(wait_pulses), 32'(e.wait_pulses));
        end
        for (int k = 0; k < NUM_REQ; k++)
          if ((ack_o[k] || err_o[k]) && req_cnt[k] > 0) req_cnt[k]--;
        starts_seen = 0;
        wait_pulses = 0;
      end
      if (!sccb_start_o) begin
        sccb_done_i      = 1'b0;
        sccb_ack_error_i = 1'b0;
        lat_cnt          = 0;
      end else if (!hang && !sccb_done_i && data_pulse_i) begin
        lat_cnt++;
        if (lat_cnt == 2) begin
          sccb_done_i      = 1'b1;
          sccb_ack_error_i = (err_left > 0);
          if (err_left > 0) err_left--;
          sccb_rdata_i     = model_rdata;
        end
      end
    end
    start_prev = sccb_start_o;
    for (int k = 0; k < NUM_REQ; k++) req_i[k] = (req_cnt[k] > 0);
    pulse_div    = (pulse_div + 1) % 4;
    data_pulse_i = (pulse_div == 0);
  end

  task automatic txn(input int k, input bit rw, input logic [15:0] d,
                     input int starts, input bit fail, input int wp);
    exp_t e;
    rw_i[k]            = rw;
    wdata_i[k*16 +: 16] = d;
    e.idx = k; e.is_err = fail; e.rw = rw; e.data = d;
    e.starts = starts; e.wait_pulses = wp;
    sb.push_back(e);
    req_cnt[k]++;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge clk_i);
      c++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
      for (int k = 0; k < NUM_REQ; k++) req_cnt[k] = 0;
    end
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  initial begin
    int c;
    rst_i = 1'b1;
    req_i = '0; rw_i = '0; wdata_i = '0;
    data_pulse_i = 1'b0; sccb_done_i = 1'b0; sccb_ack_error_i = 1'b0; sccb_rdata_i = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) req_cnt[k] = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_start", 32'(sccb_start_o), 32'h0);
    chk("rst_rw", 32'(sccb_rw_o), 32'h0);
    chk("rst_data", 32'(sccb_data_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i); #2;

    // Single clean write, then a read on requester 1 (brings rr_ptr back to 0).
    txn(0, 1'b0, 16'h1280, 1, 1'b0, 0);
    drain(500);
    model_rdata = 8'h76;
    txn(1, 1'b1, 16'h0A00, 1, 1'b0, 0);
    drain(500);

    // Contention: both held for two transactions each; rdata must stay 76.
    model_rdata = 8'h33;
    txn(0, 1'b0, 16'h1111, 1, 1'b0, 0);
    txn(1, 1'b0, 16'h2222, 1, 1'b0, 0);
    txn(0, 1'b0, 16'h1111, 1, 1'b0, 0);
    txn(1, 1'b0, 16'h2222, 1, 1'b0, 0);
    drain(2000);

    // Two ack errors then success; then errors on every attempt.
    err_left = 2;
    txn(0, 1'b0, 16'h3A04, 3, 1'b0, 0);
    drain(1000);
    err_left = 4;
    txn(1, 1'b0, 16'h3B05, 4, 1'b1, 0);
    drain(1000);

    // Controller never answers: abort after 1023 WAIT pulses, then normal service.
    hang = 1'b1;
    txn(0, 1'b0, 16'h4000, 1, 1'b1, 1023);
    drain(6000);
    hang = 1'b0;
    model_rdata = 8'hC5;
    txn(1, 1'b1, 16'h0B00, 1, 1'b0, 0);
    drain(500);

    // Reset while in WAIT: no pulse for the aborted op, rr_ptr back to 0.
    hang = 1'b1;
    req_cnt[0] = 1;
    c = 0;
    while (!sccb_start_o && c < 200) begin
      @(posedge clk_i);
      c++;
    end
    chk("start_before_reset", 32'(sccb_start_o), 32'h1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk("start_async_drop", 32'(sccb_start_o), 32'h0);
    chk("busy_async_drop", 32'(busy_o), 32'h0);
    hang = 1'b0;
    exp_rdata = 8'h00;
    req_cnt[0] = 0;
    txn(0, 1'b0, 16'h5050, 1, 1'b0, 0);
    txn(1, 1'b0, 16'h6161, 1, 1'b0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_hold_ack", 32'(ack_o), 32'h0);
    chk("rst_hold_err", 32'(err_o), 32'h0);
    #1;
    rst_i = 1'b0;
    drain(2000);

    // Lone request from requester 1 is granted directly.
    txn(1, 1'b0, 16'h7272, 1, 1'b0, 0);
    drain(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
